// File: rtl/wb_regfile_pkg.sv
// Shared writeback definitions: RegSrc encodings and datapath/address widths.
package wb_regfile_pkg;

  localparam int WB_DATA_W = 16;
  localparam int WB_ADDR_W = 3;
  localparam int WB_NREGS  = 8;
  localparam int WB_CNT_W  = 16;

  typedef enum logic [1:0] {
    RS_PC  = 2'b00,
    RS_MEM = 2'b01,
    RS_ALU = 2'b10,
    RS_BIN = 2'b11
  } regsrc_e;

endpackage

// File: rtl/wb_src_mux.sv
// 4:1 writeback source select by RegSrc; shared with the forwarding unit.
module wb_src_mux
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W
) (
  input  logic [1:0]        regsrc,
  input  logic [DATA_W-1:0] pc_data,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [DATA_W-1:0] binput,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = '0;
    case (regsrc_e'(regsrc))
      RS_PC:   data = pc_data;
      RS_MEM:  data = mem_data;
      RS_ALU:  data = alu_data;
      RS_BIN:  data = binput;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: source select, 8x16 register file, two read ports, perf counters.
// Optional same-cycle write-through to the read ports under WB_REGFILE_BYPASS_EN.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int NREGS  = WB_NREGS,
  parameter int CNT_W  = WB_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           wb_regsrc,
  input  logic [DATA_W-1:0]    wb_mem_data,
  input  logic [DATA_W-1:0]    wb_alu_data,
  input  logic [DATA_W-1:0]    wb_pc_data,
  input  logic [DATA_W-1:0]    wb_binput,
  input  logic                 wb_regwrt,
  input  logic [WB_ADDR_W-1:0] wb_write_reg,
  input  logic                 wb_sendnop,
  input  logic                 wb_branch,
  input  logic [WB_ADDR_W-1:0] rd_reg1,
  input  logic [WB_ADDR_W-1:0] rd_reg2,
  output logic [DATA_W-1:0]    rd_data1,
  output logic [DATA_W-1:0]    rd_data2,
  output logic [DATA_W-1:0]    wb_data,
  output logic                 wb_we,
  output logic [CNT_W-1:0]     retire_count,
  output logic [CNT_W-1:0]     branch_count
);

  logic [DATA_W-1:0] regs [NREGS];

  wb_src_mux #(.DATA_W(DATA_W)) u_src_mux (
    .regsrc   (wb_regsrc),
    .pc_data  (wb_pc_data),
    .mem_data (wb_mem_data),
    .alu_data (wb_alu_data),
    .binput   (wb_binput),
    .data     (wb_data)
  );

  assign wb_we = wb_regwrt & ~wb_sendnop;

  // wb_write_reg is only used as an index when wb_we is high, so an unknown
  // destination on an idle slot cannot touch the array.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs         <= '{default: '0};
      retire_count <= '0;
      branch_count <= '0;
    end else begin
      if (wb_we) begin
        regs[wb_write_reg] <= wb_data;
        retire_count       <= retire_count + CNT_W'(1);
      end
      if (wb_branch && !wb_sendnop)
        branch_count <= branch_count + CNT_W'(1);
    end
  end

  always_comb begin
    rd_data1 = regs[rd_reg1];
    rd_data2 = regs[rd_reg2];
`ifdef WB_REGFILE_BYPASS_EN
    if (wb_we && (rd_reg1 == wb_write_reg)) rd_data1 = wb_data;
    if (wb_we && (rd_reg2 == wb_write_reg)) rd_data2 = wb_data;
`endif
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized traffic vs a behavioural model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wb_regsrc;
  logic [15:0] wb_mem_data, wb_alu_data, wb_pc_data, wb_binput;
  logic        wb_regwrt;
  logic [2:0]  wb_write_reg;
  logic        wb_sendnop, wb_branch;
  logic [2:0]  rd_reg1, rd_reg2;
  logic [15:0] rd_data1, rd_data2, wb_data;
  logic        wb_we;
  logic [15:0] retire_count, branch_count;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  bit          check_en = 1'b0;

  // Behavioural model state
  logic [15:0] m_regs [8];
  logic [15:0] m_ret = '0;
  logic [15:0] m_br  = '0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk          (clk),
    .rst          (rst),
    .wb_regsrc    (wb_regsrc),
    .wb_mem_data  (wb_mem_data),
    .wb_alu_data  (wb_alu_data),
    .wb_pc_data   (wb_pc_data),
    .wb_binput    (wb_binput),
    .wb_regwrt    (wb_regwrt),
    .wb_write_reg (wb_write_reg),
    .wb_sendnop   (wb_sendnop),
    .wb_branch    (wb_branch),
    .rd_reg1      (rd_reg1),
    .rd_reg2      (rd_reg2),
    .rd_data1     (rd_data1),
    .rd_data2     (rd_data2),
    .wb_data      (wb_data),
    .wb_we        (wb_we),
    .retire_count (retire_count),
    .branch_count (branch_count)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_sel();
    logic [15:0] src [4];
    src[0] = wb_pc_data;
    src[1] = wb_mem_data;
    src[2] = wb_alu_data;
    src[3] = wb_binput;
    return src[wb_regsrc];
  endfunction

  function automatic logic exp_we();
    return wb_regwrt && !wb_sendnop;
  endfunction

  function automatic logic [15:0] exp_read(input logic [2:0] a);
`ifdef WB_REGFILE_BYPASS_EN
    if (exp_we() && a == wb_write_reg) return exp_sel();
`endif
    return m_regs[a];
  endfunction

  // Model commits on the same edge the design does, using the inputs held across it.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_ret = '0;
      m_br  = '0;
    end else begin
      if (exp_we()) begin
        m_regs[wb_write_reg] = exp_sel();
        m_ret = m_ret + 16'd1;
      end
      if (wb_branch && !wb_sendnop) m_br = m_br + 16'd1;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("rd_data1", rd_data1, exp_read(rd_reg1));
      check("rd_data2", rd_data2, exp_read(rd_reg2));
      check("wb_data", wb_data, exp_sel());
      check("wb_we", {15'd0, wb_we}, {15'd0, exp_we()});
      check("retire_count", retire_count, m_ret);
      check("branch_count", branch_count, m_br);
    end
  end

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; wb_regwrt = 0; wb_sendnop = 0; wb_branch = 0;
  endtask

  task automatic read_chk(input string name, input logic [2:0] a, input logic [15:0] exp);
    rd_reg1 = a;
    rd_reg2 = a;
    #1;
    check(name, rd_data1, exp);
    check(name, rd_data2, exp);
  endtask

  initial begin
    rst = 1; wb_regsrc = 2'b10; wb_pc_data = '0; wb_mem_data = '0; wb_alu_data = 16'h1234;
    wb_binput = '0; wb_regwrt = 1; wb_write_reg = 3'd3; wb_sendnop = 0; wb_branch = 0;
    rd_reg1 = '0; rd_reg2 = '0;

    // Reset with a write pending
    edge_step();
    check_en = 1'b1;
    idle();
    for (int a = 0; a < 8; a++) read_chk("reset_reg", 3'(a), 16'h0000);
    check("reset_retire", retire_count, 16'h0000);

    // Source select into regs 1..4
    edge_step();
    wb_pc_data = 16'h0002; wb_mem_data = 16'hBEEF; wb_alu_data = 16'h00AA; wb_binput = 16'h5555;
    wb_regwrt = 1;
    for (int i = 0; i < 4; i++) begin
      wb_regsrc = 2'(i);
      wb_write_reg = 3'(i + 1);
      edge_step();
    end
    wb_regwrt = 0;
    read_chk("src_pc", 3'd1, 16'h0002);
    read_chk("src_mem", 3'd2, 16'hBEEF);
    read_chk("src_alu", 3'd3, 16'h00AA);
    read_chk("src_bin", 3'd4, 16'h5555);
    check("src_retire", retire_count, 16'd4);

    // Bubble suppression
    edge_step();
    wb_sendnop = 1; wb_regwrt = 1; wb_write_reg = 3'd5; wb_regsrc = 2'b10; wb_alu_data = 16'hFFFF;
    settle();
    check("nop_we", {15'd0, wb_we}, 16'd0);
    edge_step();
    idle();
    read_chk("nop_reg5", 3'd5, 16'h0000);
    check("nop_retire", retire_count, 16'd4);
    check("nop_branch", branch_count, 16'd0);

    // Same-cycle write/read of reg 6
    edge_step();
    wb_regwrt = 1; wb_write_reg = 3'd6; wb_regsrc = 2'b10; wb_alu_data = 16'hCAFE;
    rd_reg1 = 3'd6; rd_reg2 = 3'd6;
    settle();
`ifdef WB_REGFILE_BYPASS_EN
    check("hazard_rd1", rd_data1, 16'hCAFE);
    check("hazard_rd2", rd_data2, 16'hCAFE);
`else
    check("hazard_rd1", rd_data1, 16'h0000);
    check("hazard_rd2", rd_data2, 16'h0000);
`endif
    edge_step();
    wb_regwrt = 0;
    #1;
    check("hazard_next_rd1", rd_data1, 16'hCAFE);
    check("hazard_next_rd2", rd_data2, 16'hCAFE);

    // Branch counting: three live, one bubbled
    wb_branch = 1;
    repeat (3) edge_step();
    wb_sendnop = 1;
    edge_step();
    idle();
    check("branch_count3", branch_count, 16'd3);

    // Reset mid-stream discards the concurrent write
    wb_regwrt = 1; wb_write_reg = 3'd2; wb_regsrc = 2'b10; wb_alu_data = 16'h1111;
    edge_step();
    read_chk("pre_rst_reg2", 3'd2, 16'h1111);
    rst = 1; wb_alu_data = 16'h7777;
    edge_step();
    idle();
    read_chk("post_rst_reg2", 3'd2, 16'h0000);
    check("post_rst_retire", retire_count, 16'd0);

    // Randomized traffic
    repeat (1500) begin
      rst          = ($urandom_range(0, 63) == 0);
      wb_regsrc    = 2'($urandom);
      wb_mem_data  = 16'($urandom);
      wb_alu_data  = 16'($urandom);
      wb_pc_data   = 16'($urandom);
      wb_binput    = 16'($urandom);
      wb_regwrt    = ($urandom_range(0, 3) != 0);
      wb_write_reg = 3'($urandom);
      wb_sendnop   = ($urandom_range(0, 4) == 0);
      wb_branch    = ($urandom_range(0, 2) == 0);
      rd_reg1      = 3'($urandom);
      rd_reg2      = ($urandom_range(0, 3) == 0) ? wb_write_reg : 3'($urandom);
      edge_step();
    end

    // Retire counter wrap
    idle();
    rst = 1;
    edge_step();
    rst = 0; wb_regwrt = 1;
    repeat (65535) begin
      wb_regsrc    = 2'($urandom);
      wb_alu_data  = 16'($urandom);
      wb_mem_data  = 16'($urandom);
      wb_write_reg = 3'($urandom);
      rd_reg1      = 3'($urandom);
      rd_reg2      = 3'($urandom);
      edge_step();
    end
    check("retire_ffff", retire_count, 16'hFFFF);
    edge_step();
    wb_regwrt = 0;
    check("retire_wrap", retire_count, 16'h0000);
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-end consumer of the MEM/WB pipeline register outputs.
- Selects the writeback data by RegSrc and commits it into an 8-entry x 16-bit architectural register file.
- Serves the two decode-stage read ports.
- Keeps retired-write and retired-branch counters for debug and perf.

Parameters:
- DATA_W, 16, register and datapath width
- NREGS, 8, number of architectural registers (address width = 3)
- CNT_W, 16, width of perf counters

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- wb_regsrc  in  2  writeback source select from MEM/WB
- wb_mem_data  in  DATA_W  memory read data from MEM/WB
- wb_alu_data  in  DATA_W  ALU result from MEM/WB
- wb_pc_data  in  DATA_W  PC+2 link value from MEM/WB
- wb_binput  in  DATA_W  B operand passthrough from MEM/WB
- wb_regwrt  in  1  register write request (already stall-gated upstream)
- wb_write_reg  in  3  destination register
- wb_sendnop  in  1  slot is a bubble; suppresses all effects
- wb_branch  in  1  retiring instruction is a branch
- rd_reg1  in  3  decode read address 1
- rd_reg2  in  3  decode read address 2
- rd_data1  out  DATA_W  read data 1
- rd_data2  out  DATA_W  read data 2
- wb_data  out  DATA_W  selected writeback data, for forwarding
- wb_we  out  1  effective write enable this cycle
- retire_count  out  CNT_W  committed register writes
- branch_count  out  CNT_W  retired branches

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Source select, combinational:
  - 2'b00 -> wb_pc_data
  - 2'b01 -> wb_mem_data
  - 2'b10 -> wb_alu_data
  - 2'b11 -> wb_binput
- Write enable: wb_we = wb_regwrt & ~wb_sendnop, combinational.
- Register write: on posedge clk with wb_we=1, reg[wb_write_reg] <= wb_data.
  - Register 0 is an ordinary writable register, not hardwired zero.
- Reads are combinational from the array: rd_dataN = reg[rd_regN].
  - Same-cycle write/read hazard is governed by the optional feature.
  - Both read ports may address the same register; both return the same value.
- retire_count: increments by 1 on each posedge with wb_we=1; wraps 0xFFFF->0x0000.
- branch_count: increments on posedge when wb_branch & ~wb_sendnop; wraps.
  - Counts per cycle. A stalled slot held for N cycles counts N times unless upstream drops wb_branch or asserts wb_sendnop.
- Reset, on posedge with rst=1:
  - All registers, retire_count and branch_count clear to 0.
  - rst has priority over a simultaneous write; no write or count occurs that cycle.
  - After reset, rd_data1/rd_data2 = 0.
  - wb_data and wb_we remain combinational functions of the inputs.
- Reset asserted mid-operation discards any write presented in that cycle.
- wb_sendnop=1 with wb_regwrt=1: no write, no count, wb_we=0.
- X on wb_write_reg while wb_we=0 must not corrupt state.

Optional Feature:
- Macro WB_REGFILE_BYPASS_EN.
- Defined: write-through bypass. If wb_we=1 and rd_regN==wb_write_reg, rd_dataN = wb_data in the same cycle.
  - Decode sees the value being written without a one-cycle wait.
  - Applies independently per read port.
- Undefined: reads return the pre-write array contents. The new value becomes visible the cycle after the write edge, and the hazard unit must stall one extra cycle.

Decomposition:
- Shared package holds:
  - RegSrc encodings: RS_PC=2'b00, RS_MEM=2'b01, RS_ALU=2'b10, RS_BIN=2'b11
  - DATA_W and register-address width constants
- One natural sub-module, wb_src_mux: the 4:1 combinational writeback select. It is reused by the forwarding unit to compute the same value.
- Register array and counters stay in wb_regfile.

Test Plan:
- Reset check: assert rst 1 cycle with wb_regwrt=1, wb_write_reg=3, alu=0x1234. Required: rd_data for all 8 addresses = 0, retire_count = 0.
- Source select: regsrc 00/01/10/11 with pc=0x0002, mem=0xBEEF, alu=0x00AA, binput=0x5555, writing regs 1-4 on consecutive cycles. Required: regs read back 0x0002, 0xBEEF, 0x00AA, 0x5555; retire_count = 4.
- Bubble suppression: wb_sendnop=1, wb_regwrt=1, wb_write_reg=5, alu=0xFFFF. Required: reg5 stays 0, wb_we=0, counters unchanged.
- Same-cycle read/write: write 0xCAFE to reg 6 while rd_reg1=rd_reg2=6.
  - Bypass defined: rd_data1 = rd_data2 = 0xCAFE in that cycle.
  - Bypass undefined: old value 0x0000 in that cycle, 0xCAFE the next cycle.
- Counter wrap: preload via 65535 writes, then one more. Required: retire_count goes 0xFFFF -> 0x0000. Also 3 cycles of wb_branch=1 with sendnop=0, then 1 cycle with sendnop=1. Required: branch_count = 3.
- Reset mid-stream: rst together with a write of 0x7777 to reg 2 after reg 2 held 0x1111. Required: reg 2 = 0 next cycle, not 0x7777.
